// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the streaming Sobel engine.
package sobel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_MAG = 1'b0;
  localparam logic MODE_BIN = 1'b1;

  function automatic int grad_w(input int pix_w);
    return pix_w + 3;
  endfunction

  function automatic int mag_w(input int pix_w);
    return pix_w + 4;
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store indexed by column; returns rows r-2/r-1 for the current column.
// Read is combinational from the old contents, then the column shifts up on write.
module sobel_line_buffer #(
  parameter int MAX_WIDTH = 640,
  parameter int PIX_W     = 8,
  parameter int AW        = $clog2(MAX_WIDTH)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    col_i,
  input  logic [PIX_W-1:0] wr_pix_i,
  output logic [PIX_W-1:0] top_o,
  output logic [PIX_W-1:0] mid_o
);

  logic [PIX_W-1:0] row1_q [MAX_WIDTH];
  logic [PIX_W-1:0] row2_q [MAX_WIDTH];

  assign top_o = row2_q[col_i];
  assign mid_o = row1_q[col_i];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      row2_q[col_i] <= row1_q[col_i];
      row1_q[col_i] <= wr_pix_i;
    end
  end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel with runtime frame size, valid/ready on both sides and
// a saturated-magnitude or thresholded-binary output; 1-cycle input-to-output latency.
module sobel_stream_engine
  import sobel_pkg::*;
#(
  parameter int MAX_WIDTH = 640,
  parameter int PIX_W     = 8,
  parameter int DIM_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] img_width,
  input  logic [DIM_W-1:0] img_height,
  input  logic             mode,
  input  logic [PIX_W+3:0] threshold,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done,
  output logic             size_err
);

  localparam int GW = grad_w(PIX_W);
  localparam int MW = mag_w(PIX_W);
  localparam int AW = $clog2(MAX_WIDTH);

  state_t state_q, state_d;

  logic [DIM_W-1:0] w_q, h_q, row_q, col_q;
  logic             mode_q;
  logic [MW-1:0]    thr_q;
  logic [PIX_W-1:0] wa_top_q, wa_mid_q, wa_bot_q;
  logic [PIX_W-1:0] wb_top_q, wb_mid_q, wb_bot_q;
  logic             ov_q, ol_q;
  logic [PIX_W-1:0] op_q;
  logic             size_err_q, rej_q;

  logic [PIX_W-1:0] lb_top, lb_mid;
  logic             dims_ok, in_fire, at_last_pix, row_end, produce;

  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]        ax, ay;
  logic [MW-1:0]        mag;
  logic [PIX_W-1:0]     sat, bin, result;

  function automatic logic [GW-1:0] wsum(input logic [PIX_W-1:0] a,
                                         input logic [PIX_W-1:0] b,
                                         input logic [PIX_W-1:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  sobel_line_buffer #(
    .MAX_WIDTH (MAX_WIDTH),
    .PIX_W     (PIX_W),
    .AW        (AW)
  ) u_lb (
    .clk      (clk),
    .wr_en_i  (in_fire),
    .col_i    (col_q[AW-1:0]),
    .wr_pix_i (in_pixel),
    .top_o    (lb_top),
    .mid_o    (lb_mid)
  );

  assign dims_ok     = (img_width >= DIM_W'(3)) && (img_width <= DIM_W'(MAX_WIDTH)) &&
                       (img_height >= DIM_W'(3));
  assign in_fire     = in_valid && in_ready;
  assign row_end     = (col_q == w_q - DIM_W'(1));
  assign at_last_pix = row_end && (row_q == h_q - DIM_W'(1));
  assign produce     = in_fire && (row_q >= DIM_W'(2)) && (col_q >= DIM_W'(2));

  // Window columns: wa = oldest, wb = middle, line buffer + in_pixel = newest.
  assign gx = $signed(wsum(lb_top, lb_mid, in_pixel)) - $signed(wsum(wa_top_q, wa_mid_q, wa_bot_q));
  assign gy = $signed(wsum(wa_bot_q, wb_bot_q, in_pixel)) - $signed(wsum(wa_top_q, wb_top_q, lb_top));
  assign ax = gx[GW-1] ? GW'(-gx) : GW'(gx);
  assign ay = gy[GW-1] ? GW'(-gy) : GW'(gy);
  assign mag = {1'b0, ax} + {1'b0, ay};

  assign sat    = (|mag[MW-1:PIX_W]) ? {PIX_W{1'b1}} : mag[PIX_W-1:0];
  assign bin    = (mag >= thr_q) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
  assign result = (mode_q == MODE_MAG) ? sat : bin;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && dims_ok) state_d = RUN;
      RUN:     if (in_fire && at_last_pix) state_d = DRAIN;
      DRAIN:   if (!ov_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == RUN) && (!ov_q || out_ready);
    busy       = (state_q != IDLE);
    frame_done = rej_q || ((state_q == DRAIN) && !ov_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q        <= '0;
      h_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
      mode_q     <= 1'b0;
      thr_q      <= '0;
      wa_top_q   <= '0;
      wa_mid_q   <= '0;
      wa_bot_q   <= '0;
      wb_top_q   <= '0;
      wb_mid_q   <= '0;
      wb_bot_q   <= '0;
      ov_q       <= 1'b0;
      ol_q       <= 1'b0;
      op_q       <= '0;
      size_err_q <= 1'b0;
      rej_q      <= 1'b0;
    end else begin
      rej_q <= 1'b0;
      if ((state_q == IDLE) && start) begin
        if (dims_ok) begin
          w_q        <= img_width;
          h_q        <= img_height;
          mode_q     <= mode;
          thr_q      <= threshold;
          row_q      <= '0;
          col_q      <= '0;
          size_err_q <= 1'b0;
        end else begin
          size_err_q <= 1'b1;
          rej_q      <= 1'b1;
        end
      end
      if (in_fire) begin
        if (row_end) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
        wa_top_q <= wb_top_q;
        wa_mid_q <= wb_mid_q;
        wa_bot_q <= wb_bot_q;
        wb_top_q <= lb_top;
        wb_mid_q <= lb_mid;
        wb_bot_q <= in_pixel;
      end
      // A new result can only land when the register is empty or draining this cycle.
      if (ov_q && out_ready) ov_q <= 1'b0;
      if (produce) begin
        ov_q <= 1'b1;
        op_q <= result;
        ol_q <= at_last_pix;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_pixel = op_q;
  assign out_last  = ol_q;
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine: directed frames, expected results queued
// at stimulus time and popped by an independent output monitor.
module tb_sobel_stream_engine;

  localparam int MAXW = 640;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] img_width = '0;
  logic [15:0] img_height = '0;
  logic        mode = 1'b0;
  logic [11:0] threshold = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_pixel = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic        busy;
  logic        frame_done;
  logic        size_err;

  sobel_stream_engine #(.MAX_WIDTH(MAXW), .PIX_W(8), .DIM_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .img_width  (img_width),
    .img_height (img_height),
    .mode       (mode),
    .threshold  (threshold),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .size_err   (size_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         done_cnt = 0;
  bit         bp_mode = 1'b0;
  logic [7:0] img [0:4][0:MAXW-1];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model(input int r, input int c, input bit md, input int thr);
    int gx, gy, m;
    gx = (int'(img[r-1][c+1]) + 2*int'(img[r][c+1]) + int'(img[r+1][c+1]))
       - (int'(img[r-1][c-1]) + 2*int'(img[r][c-1]) + int'(img[r+1][c-1]));
    gy = (int'(img[r+1][c-1]) + 2*int'(img[r+1][c]) + int'(img[r+1][c+1]))
       - (int'(img[r-1][c-1]) + 2*int'(img[r-1][c]) + int'(img[r-1][c+1]));
    m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (md) return (m >= thr) ? 255 : 0;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic push_exp(input int pix, input bit last);
    exp_t e;
    e.pix  = 8'(pix);
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic push_model(input int w, input int h, input bit md, input int thr);
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++)
        push_exp(model(r, c, md, thr), (r == h - 2) && (c == w - 2));
  endtask

  // Output monitor: pops on each transfer and checks stability while stalled.
  initial begin
    bit         hold_vld;
    logic [7:0] hold_pix;
    logic       hold_last;
    exp_t       e;
    hold_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_vld = 1'b0;
      end else begin
        if (hold_vld) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_pixel", int'(out_pixel), int'(hold_pix));
          chk("stall_last", int'(out_last), int'(hold_last));
        end
        hold_vld = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_errors++;
              $display("FAIL unexpected_output: got pixel %0d, expected no output", out_pixel);
            end else begin
              e = exp_q.pop_front();
              if (out_pixel !== e.pix || out_last !== e.last) begin
                n_errors++;
                $display("FAIL out_beat: got pixel %0d last %0b, expected pixel %0d last %0b",
                         out_pixel, out_last, e.pix, e.last);
              end
            end
          end else begin
            hold_vld  = 1'b1;
            hold_pix  = out_pixel;
            hold_last = out_last;
          end
        end
        if (frame_done) done_cnt++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_mode ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic do_start(input int w, input int h, input bit md, input int thr);
    img_width  = 16'(w);
    img_height = 16'(h);
    mode       = md;
    threshold  = 12'(thr);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [7:0] p, input bit rnd);
    int t;
    if (rnd) begin
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_pixel = p;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 1000) begin
        n_checks++;
        n_errors++;
        $display("FAIL in_ready_timeout: waited %0d cycles, expected acceptance", t);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input bit md, input int thr, input bit rnd);
    int d0, t;
    d0 = done_cnt;
    do_start(w, h, md, thr);
    @(negedge clk);
    chk("start_size_err", int'(size_err), 0);
    chk("start_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        send_pixel(img[r][c], rnd);
    t = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      t++;
      if (t > 5000) break;
    end
    chk("drain_timeout", t > 5000 ? 1 : 0, 0);
    chk("frame_done_count", done_cnt - d0, 1);
    chk("queue_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_size_err", int'(size_err), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Flat 4x4 frame: zero gradient everywhere.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'd100;
    for (int i = 0; i < 4; i++) push_exp(0, i == 3);
    run_frame(4, 4, 1'b0, 0, 1'b0);

    // Vertical step 4x3: Gx = 1020 at both centres.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) img[r][c] = (c < 2) ? 8'd0 : 8'd255;
    push_exp(255, 1'b0);
    push_exp(255, 1'b1);
    run_frame(4, 3, 1'b0, 0, 1'b0);

    // Flat frame again under output backpressure and gappy input.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) img[r][c] = 8'd100;
    for (int i = 0; i < 4; i++) push_exp(0, i == 3);
    bp_mode = 1'b1;
    run_frame(4, 4, 1'b0, 0, 1'b1);
    bp_mode = 1'b0;
    @(posedge clk);
    #1;

    // Illegal width is rejected with a done pulse and no input acceptance.
    d0 = done_cnt;
    do_start(2, 10, 1'b0, 0);
    @(negedge clk);
    chk("rej_size_err", int'(size_err), 1);
    chk("rej_frame_done", int'(frame_done), 1);
    chk("rej_in_ready", int'(in_ready), 0);
    chk("rej_busy", int'(busy), 0);
    @(negedge clk);
    chk("rej_done_pulse_end", int'(frame_done), 0);
    chk("rej_in_ready_2", int'(in_ready), 0);
    chk("rej_size_err_sticky", int'(size_err), 1);
    chk("rej_done_count", done_cnt - d0, 1);
    @(posedge clk);
    #1;

    // Threshold just above and exactly at the step magnitude.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) img[r][c] = (c < 2) ? 8'd0 : 8'd255;
    push_exp(0, 1'b0);
    push_exp(0, 1'b1);
    run_frame(4, 3, 1'b1, 1021, 1'b0);
    push_exp(255, 1'b0);
    push_exp(255, 1'b1);
    run_frame(4, 3, 1'b1, 1020, 1'b0);

    // Reset mid-frame after 7 beats, then a full 5x5 frame.
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[r][c] = 8'(r * 9 + c * 5 + ((r * c) % 7) * 3);
    d0 = done_cnt;
    do_start(5, 5, 1'b0, 0);
    for (int i = 0; i < 7; i++) send_pixel(img[i / 5][i % 5], 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_pixel", int'(out_pixel), 0);
    chk("midrst_done_count", done_cnt - d0, 0);
    @(posedge clk);
    #1;
    push_model(5, 5, 1'b0, 0);
    run_frame(5, 5, 1'b0, 0, 1'b0);

    // Full-width horizontal ramp, three rows.
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < MAXW; c++) img[r][c] = 8'(c);
    push_model(MAXW, 3, 1'b0, 0);
    run_frame(MAXW, 3, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
